// File: rtl/rr_arb.sv
// rr_arb: parametrised round-robin arbiter with a registered one-hot grant.
// The owner keeps the grant while it requests, for at most MAX_HOLD cycles
// (0 = unlimited). After a timeout the owner is passed over for that one
// decision, so other requesters get a turn.
// Optional macro ARB_FIXED_MODE_EN adds a `mode` input. With mode=1 the
// winner search always starts at index 0 and the pointer is frozen.
module rr_arb #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 8,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grt,
  output logic           grt_vld,
  output logic [IDW-1:0] grt_id
`ifdef ARB_FIXED_MODE_EN
  ,
  input  logic           mode
`endif
);

  // The hold counter only needs to count up to MAX_HOLD-1.
  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(N - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grt_q, grt_d;
  logic           grt_vld_q, grt_vld_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;

  logic           fixed_mode;
  logic           owner_req;
  logic           at_limit;
  logic [N-1:0]   scan_req;
  logic [IDW-1:0] scan_base;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic           take_winner;

`ifdef ARB_FIXED_MODE_EN
  assign fixed_mode = mode;
`else
  assign fixed_mode = 1'b0;
`endif

  // Index after v, wrapping N-1 -> 0 so a non-power-of-2 N stays in range.
  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
    return (v == LAST_IDX) ? '0 : v + 1'b1;
  endfunction

  // Position `off` steps after `base` in the circular scan order.
  function automatic logic [IDW-1:0] scan_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  assign owner_req = |(req & grt_q);
  assign at_limit  = (MAX_HOLD != 0) && (hcnt_q == HOLD_LAST);
  // On timeout the current owner is removed from this decision only. When
  // the owner has already dropped its request the mask changes nothing.
  assign scan_req  = (state_q == S_GRANT && at_limit) ? (req & ~grt_q) : req;
  assign scan_base = fixed_mode ? '0 : ptr_q;

  // Circular first-set-bit search starting at scan_base.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 0; off < N; off++) begin
      if (!win_found && scan_req[scan_idx(scan_base, off)]) begin
        win_found = 1'b1;
        win_idx   = scan_idx(scan_base, off);
      end
    end
  end

  // Next-state: hold, timeout, release and idle decisions.
  always_comb begin
    state_d     = state_q;
    grt_d       = grt_q;
    grt_vld_d   = grt_vld_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    hcnt_d      = hcnt_q;
    take_winner = 1'b0;

    case (state_q)
      S_IDLE: begin
        take_winner = win_found;
      end
      S_GRANT: begin
        if (owner_req && !at_limit) begin
          hcnt_d = hcnt_q + 1'b1;
        end else if (owner_req) begin
          if (win_found) begin
            take_winner = 1'b1;
          end else begin
            // Lone owner at its limit: re-grant and restart the burst.
            hcnt_d = '0;
            if (!fixed_mode) ptr_d = inc_wrap(id_q);
          end
        end else if (win_found) begin
          take_winner = 1'b1;
        end else begin
          state_d   = S_IDLE;
          grt_d     = '0;
          grt_vld_d = 1'b0;
          id_d      = '0;
          hcnt_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (take_winner) begin
      state_d        = S_GRANT;
      grt_d          = '0;
      grt_d[win_idx] = 1'b1;
      grt_vld_d      = 1'b1;
      id_d           = win_idx;
      hcnt_d         = '0;
      if (!fixed_mode) ptr_d = inc_wrap(win_idx);
    end
  end

  // State and output registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grt_q     <= '0;
      grt_vld_q <= 1'b0;
      id_q      <= '0;
      ptr_q     <= '0;
      hcnt_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      grt_q     <= grt_d;
      grt_vld_q <= grt_vld_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      hcnt_q    <= hcnt_d;
    end
  end

  assign grt     = grt_q;
  assign grt_vld = grt_vld_q;
  assign grt_id  = id_q;

endmodule

// File: tb/tb_rr_arb.sv
// tb_rr_arb: scoreboard bench for rr_arb. Two instances (MAX_HOLD=1 and
// MAX_HOLD=4) share one request bus. A behavioural model pushes the expected
// output for every driven cycle and a monitor pops and compares each cycle.
module tb_rr_arb;

  localparam int N   = 5;
  localparam int IDW = 3;

  typedef struct {
    logic [N-1:0]   grt;
    logic           vld;
    logic [IDW-1:0] id;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   h1_grt, h4_grt;
  logic           h1_vld, h4_vld;
  logic [IDW-1:0] h1_id, h4_id;
`ifdef ARB_FIXED_MODE_EN
  logic           mode_r;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  exp_t q_h1[$];
  exp_t q_h4[$];

  // Model state: owner (-1 = idle), pointer, hold count; [0]=MAX_HOLD 1, [1]=MAX_HOLD 4.
  int m_owner[2];
  int m_ptr[2];
  int m_hcnt[2];

  rr_arb #(.N(N), .MAX_HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .req(req),
    .grt(h1_grt), .grt_vld(h1_vld), .grt_id(h1_id)
`ifdef ARB_FIXED_MODE_EN
    , .mode(mode_r)
`endif
  );

  rr_arb #(.N(N), .MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .req(req),
    .grt(h4_grt), .grt_vld(h4_vld), .grt_id(h4_id)
`ifdef ARB_FIXED_MODE_EN
    , .mode(mode_r)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // First requester at or after `start` in circular order, skipping `excl`.
  function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
    for (int o = 0; o < N; o++) begin
      int i;
      i = (start + o) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input bit fixed, input int maxh,
                                     inout int owner, inout int ptr, inout int hcnt);
    int start;
    int w;
    start = fixed ? 0 : ptr;
    if (owner >= 0 && r[owner] && (maxh == 0 || hcnt < maxh - 1)) begin
      hcnt = hcnt + 1;
      return;
    end
    if (owner >= 0 && r[owner]) w = pick(r, start, owner);
    else                        w = pick(r, start, -1);
    if (w >= 0) begin
      owner = w;
      hcnt  = 0;
      if (!fixed) ptr = (w + 1) % N;
    end else if (owner >= 0 && r[owner]) begin
      hcnt = 0;
      if (!fixed) ptr = (owner + 1) % N;
    end else begin
      owner = -1;
      hcnt  = 0;
    end
  endfunction

  function automatic exp_t to_exp(input int owner);
    exp_t e;
    e.grt = '0;
    e.vld = 1'b0;
    e.id  = '0;
    if (owner >= 0) begin
      e.grt[owner] = 1'b1;
      e.vld        = 1'b1;
      e.id         = IDW'(owner);
    end
    return e;
  endfunction

  function automatic bit cur_fixed();
`ifdef ARB_FIXED_MODE_EN
    return mode_r;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_ptr[k]   = 0;
      m_hcnt[k]  = 0;
    end
  endfunction

  task automatic drive(input logic [N-1:0] r);
    bit fx;
    fx  = cur_fixed();
    req = r;
    model_step(r, fx, 1, m_owner[0], m_ptr[0], m_hcnt[0]);
    q_h1.push_back(to_exp(m_owner[0]));
    model_step(r, fx, 4, m_owner[1], m_ptr[1], m_hcnt[1]);
    q_h4.push_back(to_exp(m_owner[1]));
  endtask

  // One cycle: drive at the falling edge, return just after the rising edge.
  task automatic step(input logic [N-1:0] r);
    @(negedge clk);
    rst = 1'b1;
    drive(r);
    @(posedge clk);
    #2;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_h1_grt"}, 32'(h1_grt), 0);
    check({tag, "_h1_vld"}, 32'(h1_vld), 0);
    check({tag, "_h1_id"},  32'(h1_id),  0);
    check({tag, "_h4_grt"}, 32'(h4_grt), 0);
    check({tag, "_h4_vld"}, 32'(h4_vld), 0);
    check({tag, "_h4_id"},  32'(h4_id),  0);
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear at once.
  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 expect_idle("rst_async");
    model_reset();
    req = '1;
    repeat (2) @(posedge clk);
    #2 check("rst_held_h1_grt", 32'(h1_grt), 0);
  endtask

  task automatic compare(input string tag, input exp_t e, input logic [N-1:0] g,
                         input logic v, input logic [IDW-1:0] id);
    check({tag, "_grt"}, 32'(g),  32'(e.grt));
    check({tag, "_vld"}, 32'(v),  32'(e.vld));
    check({tag, "_id"},  32'(id), 32'(e.id));
  endtask

  // Monitor: after every rising edge, compare outputs against queued expectations.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_h1.size() > 0) compare("sb_h1", q_h1.pop_front(), h1_grt, h1_vld, h1_id);
      if (q_h4.size() > 0) compare("sb_h4", q_h4.pop_front(), h4_grt, h4_vld, h4_id);
    end
  end

  initial begin
    logic [N-1:0] r;
    rst = 1'b0;
    req = '1;
`ifdef ARB_FIXED_MODE_EN
    mode_r = 1'b0;
`endif
    model_reset();

    // Reset held with every requester active.
    repeat (3) @(posedge clk);
    #2 expect_idle("reset");

    // Release: first grant is index 0; MAX_HOLD=1 rotates 0..4 one cycle each.
    for (int i = 0; i < 10; i++) begin
      step('1);
      check("rr_h1_id", 32'(h1_id), i % N);
    end

    // Hold and timeout: 00001 x4, 00100 x4, 00001 x4.
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      step(5'b00101);
      check("hold_h4_grt", 32'(h4_grt), ((i / 4) % 2 == 0) ? 32'd1 : 32'd4);
    end

    // Owner 2 drops while 4 requests: no idle bubble; then all drop.
    apply_reset();
    step(5'b00100);
    check("own2_h4_grt", 32'(h4_grt), 32'b00100);
    step(5'b10100);
    step(5'b10100);
    step(5'b10000);
    check("nobubble_h4_grt", 32'(h4_grt), 32'b10000);
    step(5'b00000);
    check("drop_h4_grt", 32'(h4_grt), 0);
    check("drop_h4_vld", 32'(h4_vld), 0);

    // Lone owner 4 with pointer wrapped to 0: keeps the grant across timeouts.
    for (int i = 0; i < 10; i++) begin
      step(5'b10000);
      check("lone_h4_grt", 32'(h4_grt), 32'b10000);
      check("lone_h1_grt", 32'(h1_grt), 32'b10000);
    end
    // A competitor arriving part-way through a re-granted burst.
    for (int i = 0; i < 6; i++) step(5'b10001);
    // A non-owner dropping its request has no effect.
    step(5'b10011);
    step(5'b10001);

`ifdef ARB_FIXED_MODE_EN
    begin
      bit seen4;
      apply_reset();
      mode_r = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step(5'b11010);
        check("fixed_h1_id", 32'(h1_id), (i % 2 == 0) ? 32'd1 : 32'd3);
        check("fixed_h1_no4", 32'(h1_grt[4]), 0);
      end
      mode_r = 1'b0;
      seen4  = 1'b0;
      for (int i = 0; i < N; i++) begin
        step(5'b11010);
        if (h1_grt[4]) seen4 = 1'b1;
      end
      check("rr_after_fixed_4", 32'(seen4), 1);
    end
`endif

    // Randomised traffic, including a reset in the middle of a burst.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) apply_reset();
`ifdef ARB_FIXED_MODE_EN
      if (i % 16 == 0) mode_r = 1'($urandom_range(0, 1));
`endif
      case ($urandom_range(0, 3))
        0:       r = N'($urandom() & $urandom());
        1:       r = (N'($urandom_range(0, 1))) << $urandom_range(0, N - 1);
        2:       r = m_owner[1] >= 0 ? req : N'($urandom());
        default: r = N'($urandom());
      endcase
      step(r);
    end

    @(negedge clk);
    check("sb_drain", q_h1.size() + q_h4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arb.md
Name: rr_arb

Overview:
- Parametrised round-robin arbiter; successor to the fixed-priority 5-way combinational arbiter.
- Grants one of N requesters per cycle through a registered one-hot grant.
- Grant is held while the owner keeps requesting, with a bounded burst length.
- Sits in front of shared resources (bus, memory port, FIFO write side) where fixed priority would starve low-index requesters.

Parameters:
- N, 5, number of requesters (2..32).
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant; 0 means unlimited hold.
- IDW, derived = max(1, clog2(N)), width of grant index. Not user-set.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately; release is expected synchronous to clk.
- req  input  N  request vector; bit i = requester i wants the resource.
- grt  output  N  registered one-hot grant; all-zero when idle.
- grt_vld  output  1  high when any grt bit is set.
- grt_id  output  IDW  binary index of the granted requester; 0 when idle.
- mode  input  1  present only with ARB_FIXED_MODE_EN; 1 = fixed priority, 0 = round robin.

Behaviour:
- Reset (rst=0, asynchronous):
  - grt=0, grt_vld=0, grt_id=0.
  - State IDLE; priority pointer ptr=0; hold counter hcnt=0.
- Winner search:
  - Scan req circularly starting at ptr: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - The first set bit wins. An optional exclude mask removes the current owner from the scan.
- State IDLE:
  - req==0: stay IDLE, outputs zero.
  - Any req bit set: on the next edge load grt with the winner one-hot and go to GRANT.
  - Latency is 1 cycle from req sampled to grt visible.
- State GRANT, owner k:
  - Hold: req[k]=1 and (MAX_HOLD==0 or hcnt<MAX_HOLD-1). Keep grt; hcnt increments.
  - Release: req[k]=0. On the same edge grant the next winner among the remaining req bits (no idle bubble). If none, go IDLE with grt=0.
  - Timeout: req[k]=1 and hcnt==MAX_HOLD-1.
    - Other requesters present: grant the next winner, excluding k.
    - No other requester: k keeps the grant.
    - In both cases hcnt resets to 0.
  - Every new grant load sets hcnt=0 and ptr=(winner+1) mod N. A re-grant to the same owner after timeout also sets ptr=(k+1) mod N.
- Outputs:
  - grt is always zero or one-hot.
  - grt_vld = |grt; grt_id is consistent with grt in the same cycle.
  - All outputs come straight from flops; there is no combinational path from req.
- Fairness: with all N requesting continuously and MAX_HOLD=1, grant rotates 0,1,...,N-1,0,... with exactly one cycle each.
- Boundary cases:
  - ptr wraps N-1 -> 0.
  - A requester asserting in the same cycle another releases competes normally from ptr.
  - A req bit for a non-owner dropping has no effect.
  - Reset mid-burst returns to IDLE immediately; the first post-reset grant is searched from index 0.
- Arithmetic: hcnt is wide enough for MAX_HOLD-1 (min 1 bit). ptr is IDW bits and is compared modulo N, so non-power-of-2 N never produces an out-of-range pointer.

Optional Feature:
- Macro ARB_FIXED_MODE_EN.
- Defined: adds the mode input.
  - mode=1: winner search always starts at index 0 (index 0 highest priority, matching the legacy fixed-priority arbiter ordering), and ptr is not updated.
  - Hold and MAX_HOLD rules still apply. On timeout the owner is excluded for that one decision only.
  - mode may change at any time; it takes effect on the next grant decision.
- Not defined: no mode port; round-robin only; logic identical to mode=0.

Test Plan:
- Reset: hold rst=0 with req=5'b11111 -> grt=0, grt_vld=0, grt_id=0. Release rst -> one cycle later grt=5'b00001, grt_id=0.
- Round robin: N=5, MAX_HOLD=1, req=5'b11111 for 10 cycles -> grt_id sequence 0,1,2,3,4,0,1,2,3,4.
- Hold and timeout:
  - Stimulus: MAX_HOLD=4, req=5'b00101 held.
  - Required: grt=00001 for 4 cycles, then 00100 for 4 cycles, then 00001.
- Release without bubble:
  - Stimulus: owner 2 drops req while req[4]=1.
  - Required: next cycle grt=5'b10000. All req then drop -> next cycle grt=0, grt_vld=0.
- Wrap and lone timeout:
  - Stimulus: owner 4, ptr wraps to 0, req=5'b10000 held, MAX_HOLD=4.
  - Required: grt stays 5'b10000 indefinitely, with hcnt restarting every 4 cycles.
- ARB_FIXED_MODE_EN with mode=1, MAX_HOLD=1, req=5'b11010 -> grt_id sequence 1,3,1,3,...; index 4 is never granted while 1 and 3 keep requesting. Switch to mode=0 -> 4 is granted within N cycles.
